// File: rtl/fa4_pkg.sv
// Purpose: shared constants and types for the fa4 adder leaf cell.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ADDER_WIDTH   default operand/sum width of fa4_adder
//   fa4_result_t  {carry, sum} result at ADDER_WIDTH+1 bits
//   fa4_ref_sum   plain-arithmetic reference {co,s} = a + b + ci
package fa4_pkg;

  localparam int ADDER_WIDTH = 4;

  // Carry-out lives in the MSB, sum in the low ADDER_WIDTH bits.
  typedef logic [ADDER_WIDTH:0] fa4_result_t;

  // Reference addition at the default width. The operands are
  // zero-extended before the add so that the carry lands in the MSB
  // instead of being truncated away.
  function automatic fa4_result_t fa4_ref_sum(
    input logic [ADDER_WIDTH-1:0] a,
    input logic [ADDER_WIDTH-1:0] b,
    input logic                   ci
  );
    fa4_result_t w_ext_a;
    fa4_result_t w_ext_b;
    fa4_result_t w_ext_ci;
    w_ext_a  = {1'b0, a};
    w_ext_b  = {1'b0, b};
    w_ext_ci = {{ADDER_WIDTH{1'b0}}, ci};
    return w_ext_a + w_ext_b + w_ext_ci;
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Purpose: 1-bit full adder, the ripple stage of the structural path.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
//
// Ports:
//   a, b  operand bits
//   ci    carry in from the previous stage (or the adder carry-in)
//   s     sum bit
//   co    carry out to the next stage
module full_adder_1b
  import fa4_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term. It is shared by the sum and the carry.
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  // Generate (a&b), or propagate an incoming carry through (a^b).
  assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/fa4_adder.sv
// Purpose: WIDTH-bit adder. It computes the sum on a structural ripple path
//          and on a behavioural path, and cross-checks the two results.
// Latency: 1 cycle. Inputs sampled on a rising edge appear on the outputs
//          after that same edge.
// Backpressure: none. A new operand set is accepted every cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; clears every output
//   a, b      unsigned WIDTH-bit operands
//   ci        carry-in
//   s1, co1   registered sum and carry from the full-adder ripple chain
//   s2, co2   registered sum and carry from the single multi-bit addition
//   mismatch  registered flag, set when {co1,s1} != {co2,s2} for one sample
//
// WIDTH is legal from 1 to 32. The carry-out is always a single bit.
module fa4_adder
  import fa4_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s1,
  output logic             co1,
  output logic [WIDTH-1:0] s2,
  output logic             co2,
  output logic             mismatch
);

  // ---------------------------------------------------------------------------
  // Structural path: a ripple chain of full adders.
  // w_carry[0] is the external carry-in. w_carry[WIDTH] is the chain
  // carry-out.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum_struct;

  assign w_carry[0] = ci;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
    full_adder_1b u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (w_carry[gi]),
      .s  (w_sum_struct[gi]),
      .co (w_carry[gi+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Behavioural path: one (WIDTH+1)-bit addition of the zero-extended
  // operands. The extra MSB holds the carry-out.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] w_ext_a;
  logic [WIDTH:0] w_ext_b;
  logic [WIDTH:0] w_ext_ci;
  logic [WIDTH:0] w_res_beh;

  assign w_ext_a   = {1'b0, a};
  assign w_ext_b   = {1'b0, b};
  assign w_ext_ci  = {{WIDTH{1'b0}}, ci};
  assign w_res_beh = w_ext_a + w_ext_b + w_ext_ci;

  // ---------------------------------------------------------------------------
  // Cross-check. Both results come from the same combinational sample, so
  // any difference is a real disagreement between the two paths and not a
  // pipeline skew.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] w_res_struct;
  logic           w_mismatch;

  assign w_res_struct = {w_carry[WIDTH], w_sum_struct};
  assign w_mismatch   = (w_res_struct != w_res_beh);

  // ---------------------------------------------------------------------------
  // Output register stage. Reset is synchronous, so the inputs are ignored
  // on any edge where rst_n is low.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_s1;
  logic             r_co1;
  logic [WIDTH-1:0] r_s2;
  logic             r_co2;
  logic             r_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_co1      <= 1'b0;
      r_s2       <= '0;
      r_co2      <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_s1       <= w_sum_struct;
      r_co1      <= w_carry[WIDTH];
      r_s2       <= w_res_beh[WIDTH-1:0];
      r_co2      <= w_res_beh[WIDTH];
      r_mismatch <= w_mismatch;
    end
  end

  assign s1       = r_s1;
  assign co1      = r_co1;
  assign s2       = r_s2;
  assign co2      = r_co2;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_fa4_adder.sv
// Purpose: self-checking bench for fa4_adder at WIDTH=4, using directed and
//          randomized vectors checked against an integer reference model.
// Latency: the expected result of each vector is checked one edge after it
//          is applied.
// Backpressure: n/a.
module tb_fa4_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [W-1:0] s1;
  logic         co1;
  logic [W-1:0] s2;
  logic         co2;
  logic         mismatch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fa4_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .ci       (ci),
    .s1       (s1),
    .co1      (co1),
    .s2       (s2),
    .co2      (co2),
    .mismatch (mismatch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one vector, wait one edge, and compare against integer
  // arithmetic. If reset is applied, the expected result is all zeros.
  task automatic step(input logic rst, input int av, input int bv, input int civ,
                      input string tag);
    int           total;
    logic [W-1:0] exp_s;
    logic         exp_co;
    rst_n = rst;
    a     = av[W-1:0];
    b     = bv[W-1:0];
    ci    = civ[0];
    total = rst ? (av + bv + civ) : 0;
    exp_s  = total[W-1:0];
    exp_co = total[W];
    @(posedge clk);
    #1;
    check({tag, "_s1"},  32'(s1),       32'(exp_s));
    check({tag, "_co1"}, 32'(co1),      32'(exp_co));
    check({tag, "_s2"},  32'(s2),       32'(exp_s));
    check({tag, "_co2"}, 32'(co2),      32'(exp_co));
    check({tag, "_mm"},  32'(mismatch), 32'd0);
    // The outputs must hold until the next rising edge.
    @(negedge clk);
    check({tag, "_hold"}, 32'({co1, s1}), 32'({exp_co, exp_s}));
  endtask

  int vec[512];

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    @(negedge clk);

    // Reset with live inputs, then release.
    step(1'b0, 'hA, 'h5, 1, "rst0");
    step(1'b0, 'hA, 'h5, 1, "rst1");
    step(1'b1, 'hA, 'h5, 1, "rst_rel");

    // Directed corners.
    step(1'b1, 'hF, 'h0, 1, "ripple_ci");
    step(1'b1, 'hF, 'h1, 0, "ripple_b");
    step(1'b1, 'h5, 'h3, 1, "nocarry");
    step(1'b1, 'h0, 'h0, 0, "zero");
    step(1'b1, 'hF, 'hF, 1, "max");

    // Exhaustive sweep of all 512 {ci,a,b} vectors in shuffled order,
    // with one mid-stream reset cycle.
    for (int i = 0; i < 512; i++) vec[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j;
      int t;
      j      = int'($urandom_range(i, 0));
      t      = vec[i];
      vec[i] = vec[j];
      vec[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      if (i == 256)
        step(1'b0, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
             int'($urandom_range(1, 0)), "mid_rst");
      step(1'b1, vec[i] & 15, (vec[i] >> 4) & 15, (vec[i] >> 8) & 1, "sweep");
    end

    // Additional random back-to-back traffic.
    for (int i = 0; i < 100; i++)
      step(1'b1, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
           int'($urandom_range(1, 0)), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
